axis_result_collector_16: RTL
=============================

Name: axis_result_collector_16

Overview:
- AXI4-Stream slave that sinks the 16-bit softmax result stream from top_block_16's m_axis port.
- Captures one frame, terminated by last, into an internal buffer.
- Holds the frame for a host or bench read port until the frame is acknowledged, then re-arms for the next frame.
- Reports frame length and framing errors: short frame, or missing last.

Parameters:
- data_size, 16, width of the result word (matches top_block_16 output width).
- depth, 10, number of words in one full softmax vector / buffer capacity.
- addr_w, 4, width of the read address and length fields; must satisfy 2^addr_w > depth.

Ports:
- axi_clock_i  in  1  single system clock, rising edge.
- axi_reset_n_i  in  1  reset, asynchronous assert, active-low.
- s_axis_valid_i  in  1  upstream word valid.
- s_axis_data_i  in  data_size  signed result word.
- s_axis_last_i  in  1  final word of the frame.
- s_axis_ready_o  out  1  collector can accept a word; registered.
- rd_en_i  in  1  read strobe.
- rd_addr_i  in  addr_w  buffer read address.
- rd_data_o  out  data_size  read data; registered, 1-cycle latency.
- frame_done_o  out  1  frame captured and held.
- frame_len_o  out  addr_w  number of words captured in the held frame.
- short_frame_o  out  1  last arrived before depth words.
- missing_last_o  out  1  depth words arrived without last.
- frame_ack_i  in  1  release the held frame; single-cycle pulse.
- frame_cnt_o  out  8  completed-frame counter; wraps 255->0.

Behaviour:
- Reset values, all outputs while axi_reset_n_i=0:
  - s_axis_ready_o=0, rd_data_o=0, frame_done_o=0, frame_len_o=0, short_frame_o=0, missing_last_o=0, frame_cnt_o=0.
  - State=RECV, wr_ptr=0. Buffer contents are undefined.
- Ready after reset: s_axis_ready_o rises on the first rising edge after reset release.
- Handshake:
  - A beat is accepted when s_axis_valid_i & s_axis_ready_o at a rising edge.
  - On accept, mem[wr_ptr]<=s_axis_data_i and wr_ptr<=wr_ptr+1.
  - Data is stored bit-exact; no arithmetic is performed.
- States:
  - RECV: ready=1.
    - Accept with last=1 and wr_ptr+1==depth -> DONE, normal frame, no error flags.
    - Accept with last=1 and wr_ptr+1<depth -> DONE, short_frame_o=1.
    - Accept with last=0 and wr_ptr+1==depth -> DONE, missing_last_o=1.
    - Accept with last=0 and wr_ptr+1<depth -> stay in RECV.
  - DONE: ready=0, frame_done_o=1, frame_len_o=wr_ptr (the accepted count).
    - frame_cnt_o increments once on entry to DONE.
    - frame_ack_i=1 -> RECV, wr_ptr=0, all flags and frame_len_o cleared, ready=1 on the next edge.
- Ready timing:
  - s_axis_ready_o is registered; it falls on the same edge that accepts the terminating beat.
  - No beat is accepted after the terminating beat; upstream stalls while in DONE.
- Reads:
  - Valid in any state.
  - rd_en_i=1 and rd_addr_i<depth -> rd_data_o<=mem[rd_addr_i] on the next edge.
  - rd_addr_i>=depth -> rd_data_o<=0.
  - rd_en_i=0 -> rd_data_o holds.
  - Read and write to the same address in one cycle returns the old contents.
- Boundary conditions:
  - frame_ack_i in RECV is ignored.
  - frame_ack_i together with s_axis_valid_i in DONE: no accept that cycle; the beat is taken after re-arm.
  - last with valid=0 is ignored.
  - Valid deasserted mid-frame: wr_ptr holds, no timeout.
  - Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded.

Decomposition:
- Shared package softmax_pkg holds:
  - data_size default (16) and depth default (10).
  - Collector state encoding: RECV=1'b0, DONE=1'b1.
- One sub-module, result_buffer_16: depth x data_size register array with one synchronous write port and one registered read port including the out-of-range-returns-0 rule.
- The FSM, counters and flags stay in axis_result_collector_16.

Test Plan:
- Full frame: 10 beats 16'h0001..16'h000A with last on beat 10, valid held high:
  - ready=1 for 10 cycles, then 0.
  - frame_done_o=1, frame_len_o=10, no error flags, frame_cnt_o=1.
  - Reads of addr 0..9 return 16'h0001..16'h000A one cycle after each strobe.
- Short frame: 4 beats 16'h7FFF,16'h8000,16'h1234,16'hFFFF with last on beat 4:
  - frame_len_o=4, short_frame_o=1.
  - Read addr 1 returns 16'h8000.
  - Read addr 12 returns 0.
- Missing last: 12 beats with no last:
  - Exactly 10 beats are accepted; ready falls after beat 10.
  - missing_last_o=1, frame_len_o=10.
  - Beats 11 and 12 are stalled until frame_ack_i; after the ack they are accepted as words 0 and 1 of the next frame.
- Backpressure and gaps: valid toggles 1,0,1,0 across a 10-word frame; a second frame is sent after frame_ack_i:
  - No words are lost or duplicated.
  - frame_cnt_o goes 1 then 2.
  - frame_ack_i issued in RECV has no effect.
- Reset mid-frame: axi_reset_n_i pulsed low after 5 beats:
  - All outputs are 0 asynchronously.
  - The next 10-word frame gives frame_len_o=10 and frame_cnt_o=1.

Source files
------------

// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared defaults and collector state encoding
package softmax_pkg;

  localparam int data_size_dflt = 16;
  localparam int depth_dflt     = 10;

  localparam logic [0:0] RECV = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

endpackage

// File: rtl/result_buffer_16.sv
// rtl/result_buffer_16.sv - depth x data_size register array, one write port, registered read port
module result_buffer_16
  import softmax_pkg::*;
#(
  parameter int data_size = data_size_dflt,
  parameter int depth     = depth_dflt,
  parameter int addr_w    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [addr_w-1:0]    wr_addr,
  input  logic [data_size-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [addr_w-1:0]    rd_addr,
  output logic [data_size-1:0] rd_data
);

  localparam logic [addr_w-1:0] depth_a = addr_w'(depth);

  logic [data_size-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Same-cycle read of the written address returns the previous word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (rd_addr < depth_a) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/axis_result_collector_16.sv
// rtl/axis_result_collector_16.sv - captures one stream frame, holds it for reads until acknowledged
module axis_result_collector_16
  import softmax_pkg::*;
#(
  parameter int data_size = data_size_dflt,
  parameter int depth     = depth_dflt,
  parameter int addr_w    = 4
) (
  input  logic                 axi_clock_i,
  input  logic                 axi_reset_n_i,
  input  logic                 s_axis_valid_i,
  input  logic [data_size-1:0] s_axis_data_i,
  input  logic                 s_axis_last_i,
  output logic                 s_axis_ready_o,
  input  logic                 rd_en_i,
  input  logic [addr_w-1:0]    rd_addr_i,
  output logic [data_size-1:0] rd_data_o,
  output logic                 frame_done_o,
  output logic [addr_w-1:0]    frame_len_o,
  output logic                 short_frame_o,
  output logic                 missing_last_o,
  input  logic                 frame_ack_i,
  output logic [7:0]           frame_cnt_o
);

  localparam logic [addr_w-1:0] last_idx = addr_w'(depth - 1);

  logic [0:0]        state;
  logic [addr_w-1:0] wr_ptr;
  logic              accept;
  logic              last_slot;

  assign accept    = s_axis_valid_i & s_axis_ready_o;
  assign last_slot = (wr_ptr == last_idx);

  always_ff @(posedge axi_clock_i or negedge axi_reset_n_i) begin
    if (!axi_reset_n_i) begin
      state          <= RECV;
      wr_ptr         <= '0;
      s_axis_ready_o <= 1'b0;
      short_frame_o  <= 1'b0;
      missing_last_o <= 1'b0;
      frame_cnt_o    <= '0;
    end else if (state == RECV) begin
      s_axis_ready_o <= 1'b1;
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        // Frame ends on last or when the buffer fills, whichever comes first.
        if (s_axis_last_i || last_slot) begin
          state          <= DONE;
          s_axis_ready_o <= 1'b0;
          frame_cnt_o    <= frame_cnt_o + 8'd1;
          short_frame_o  <= s_axis_last_i & ~last_slot;
          missing_last_o <= ~s_axis_last_i;
        end
      end
    end else if (frame_ack_i) begin
      state          <= RECV;
      wr_ptr         <= '0;
      s_axis_ready_o <= 1'b1;
      short_frame_o  <= 1'b0;
      missing_last_o <= 1'b0;
    end
  end

  assign frame_done_o = (state == DONE);
  assign frame_len_o  = frame_done_o ? wr_ptr : '0;

  result_buffer_16 #(
    .data_size (data_size),
    .depth     (depth),
    .addr_w    (addr_w)
  ) u_buffer (
    .clk     (axi_clock_i),
    .rst_n   (axi_reset_n_i),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (s_axis_data_i),
    .rd_en   (rd_en_i),
    .rd_addr (rd_addr_i),
    .rd_data (rd_data_o)
  );

endmodule
